// File: rtl/gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_seq_ctrl
// Function : Runs a chain of sync/gate/length timer profiles for N passes,
//            counts gate pulses and reports sequence completion.
//            Optional watchdog on RUN length: define SEQ_WDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
module gate_seq_ctrl #(
    parameter int NPROF      = 4,
    parameter int PW         = 2,
    parameter int RW         = 8,
    parameter int WDOG_LIMIT = 1048575
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_addr,
    input  logic [1:0]    cfg_sel,
    input  logic [15:0]   cfg_wdata,
    input  logic          start,
    input  logic [PW-1:0] first_prof,
    input  logic [PW:0]   num_prof,
    input  logic [RW-1:0] num_pass,
    input  logic          abort,
    input  logic          tmr_Done,
    input  logic          tmr_Gate,
    output logic          busy,
    output logic          seq_done,
    output logic [PW-1:0] cur_prof,
    output logic [15:0]   gate_cnt,
    output logic          wdog_err,
    output logic          tmr_rst,
    output logic          tmr_ena,
    output logic [7:0]    tmr_Tsync,
    output logic [7:0]    tmr_Tgdel,
    output logic [15:0]   tmr_Tgate,
    output logic [15:0]   tmr_Tlen
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_tsync [NPROF];
    logic [7:0]    r_tgdel [NPROF];
    logic [15:0]   r_tgate [NPROF];
    logic [15:0]   r_tlen  [NPROF];

    logic [PW-1:0] r_first;
    logic [PW-1:0] r_cur_prof;
    logic [PW:0]   r_nprof_m1;
    logic [PW:0]   r_prof_idx;
    logic [RW-1:0] r_npass_m1;
    logic [RW-1:0] r_pass_idx;
    logic [15:0]   r_gate_cnt;
    logic          r_gate_d;
    logic          r_seq_done;
    logic [7:0]    r_tmr_tsync;
    logic [7:0]    r_tmr_tgdel;
    logic [15:0]   r_tmr_tgate;
    logic [15:0]   r_tmr_tlen;

    logic          w_start_ok;
    logic          w_chain_end;
    logic          w_last;
    logic          w_gate_rise;
    logic          w_wdog_hit;
    logic          w_busy;
    logic          w_tmr_rst;
    logic          w_tmr_ena;

    assign w_start_ok  = start && (num_prof != '0) && (num_pass != '0);
    assign w_chain_end = (r_prof_idx == r_nprof_m1);
    assign w_last      = w_chain_end && (r_pass_idx == r_npass_m1);
    assign w_gate_rise = tmr_Gate && !r_gate_d;

`ifdef SEQ_WDOG_EN
    logic [19:0]   r_wdog_cnt;
    logic          r_wdog_err;

    assign w_wdog_hit = (r_state == S_RUN) && (r_wdog_cnt == 20'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == S_LOAD)
                r_wdog_cnt <= '0;
            else if (r_state == S_RUN)
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            if ((r_state == S_IDLE) && w_start_ok)
                r_wdog_err <= 1'b0;
            else if (w_wdog_hit && !abort && !tmr_Done)
                r_wdog_err <= 1'b1;
        end
    end

    assign wdog_err = r_wdog_err;
`else
    logic          w_unused_wdog;
    assign w_unused_wdog = (WDOG_LIMIT != 0);
    assign w_wdog_hit    = 1'b0;
    assign wdog_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Abort beats Done, Done beats the watchdog
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_tmr_rst   = 1'b0;
        w_tmr_ena   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy    = 1'b0;
                w_tmr_rst = 1'b1;
                if (w_start_ok)
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_tmr_rst   = 1'b1;
                w_state_nxt = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                w_tmr_ena = 1'b1;
                if (abort)
                    w_state_nxt = S_IDLE;
                else if (tmr_Done)
                    w_state_nxt = w_last ? S_IDLE : S_GAP;
                else if (w_wdog_hit)
                    w_state_nxt = S_IDLE;
            end
            S_GAP: begin
                w_state_nxt = abort ? S_IDLE : S_LOAD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NPROF; i++) begin
                r_tsync[i] <= '0;
                r_tgdel[i] <= '0;
                r_tgate[i] <= '0;
                r_tlen[i]  <= '0;
            end
        end else if (cfg_we && (r_state == S_IDLE)) begin
            case (cfg_sel)
                2'd0:    r_tsync[cfg_addr] <= cfg_wdata[7:0];
                2'd1:    r_tgdel[cfg_addr] <= cfg_wdata[7:0];
                2'd2:    r_tgate[cfg_addr] <= cfg_wdata;
                default: r_tlen[cfg_addr]  <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first     <= '0;
            r_cur_prof  <= '0;
            r_nprof_m1  <= '0;
            r_prof_idx  <= '0;
            r_npass_m1  <= '0;
            r_pass_idx  <= '0;
            r_gate_cnt  <= '0;
            r_gate_d    <= 1'b0;
            r_seq_done  <= 1'b0;
            r_tmr_tsync <= '0;
            r_tmr_tgdel <= '0;
            r_tmr_tgate <= '0;
            r_tmr_tlen  <= '0;
        end else begin
            r_gate_d   <= tmr_Gate;
            r_seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_first    <= first_prof;
                        r_cur_prof <= first_prof;
                        r_nprof_m1 <= num_prof - (PW+1)'(1);
                        r_npass_m1 <= num_pass - RW'(1);
                        r_prof_idx <= '0;
                        r_pass_idx <= '0;
                        r_gate_cnt <= '0;
                    end else if (start) begin
                        r_seq_done <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tmr_tsync <= r_tsync[r_cur_prof];
                    r_tmr_tgdel <= r_tgdel[r_cur_prof];
                    r_tmr_tgate <= r_tgate[r_cur_prof];
                    r_tmr_tlen  <= r_tlen[r_cur_prof];
                end
                S_RUN: begin
                    if (!abort) begin
                        if (w_gate_rise && (r_gate_cnt != 16'hFFFF))
                            r_gate_cnt <= r_gate_cnt + 1'b1;
                        if (tmr_Done) begin
                            if (w_last) begin
                                r_seq_done <= 1'b1;
                            end else if (w_chain_end) begin
                                r_cur_prof <= r_first;
                                r_prof_idx <= '0;
                                r_pass_idx <= r_pass_idx + 1'b1;
                            end else begin
                                r_cur_prof <= r_cur_prof + 1'b1;
                                r_prof_idx <= r_prof_idx + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = w_busy;
    assign tmr_rst   = w_tmr_rst;
    assign tmr_ena   = w_tmr_ena;
    assign seq_done  = r_seq_done;
    assign cur_prof  = r_cur_prof;
    assign gate_cnt  = r_gate_cnt;
    assign tmr_Tsync = r_tmr_tsync;
    assign tmr_Tgdel = r_tmr_tgdel;
    assign tmr_Tgate = r_tmr_tgate;
    assign tmr_Tlen  = r_tmr_tlen;

endmodule
`default_nettype wire

// File: tb/tb_gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_seq_ctrl
// Function : Scoreboard bench for gate_seq_ctrl with a behavioural timer.
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_seq_ctrl;

    typedef struct packed {
        logic [7:0]  ts;
        logic [7:0]  tg;
        logic [15:0] tgt;
        logic [15:0] tl;
        logic [15:0] gc;
        logic [1:0]  prof;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic [1:0]  first_prof = '0;
    logic [2:0]  num_prof = '0;
    logic [7:0]  num_pass = '0;
    logic        abort = 1'b0;
    logic        tmr_Done = 1'b0;
    logic        tmr_Gate = 1'b0;
    logic        busy, seq_done, wdog_err, tmr_rst, tmr_ena;
    logic [1:0]  cur_prof;
    logic [15:0] gate_cnt, tmr_Tgate, tmr_Tlen;
    logic [7:0]  tmr_Tsync, tmr_Tgdel;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_load = 0;
    int          n_gap = 0;
    int          n_ena = 0;
    int          ena_cnt = 0;
    int          done_at = 15;
    bit          tb_done = 1'b0;
    bit          prev_start = 1'b0;
    bit          prev_done = 1'b0;
    exp_t        sb[$];
    logic [1:0]  prof_log[$];

    gate_seq_ctrl #(.NPROF(4), .PW(2), .RW(8), .WDOG_LIMIT(100)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .start(start),
        .first_prof(first_prof), .num_prof(num_prof), .num_pass(num_pass),
        .abort(abort), .tmr_Done(tmr_Done), .tmr_Gate(tmr_Gate),
        .busy(busy), .seq_done(seq_done), .cur_prof(cur_prof),
        .gate_cnt(gate_cnt), .wdog_err(wdog_err), .tmr_rst(tmr_rst),
        .tmr_ena(tmr_ena), .tmr_Tsync(tmr_Tsync), .tmr_Tgdel(tmr_Tgdel),
        .tmr_Tgate(tmr_Tgate), .tmr_Tlen(tmr_Tlen)
    );

    always #5 clk = ~clk;

    // Timer model: Done in enable cycle done_at, one Gate pulse in cycles 3..5
    always @(posedge clk) begin
        #1;
        if (tmr_ena) ena_cnt = ena_cnt + 1;
        else         ena_cnt = 0;
        tmr_Done = tmr_ena && (done_at != 0) && (ena_cnt == done_at);
        tmr_Gate = tmr_ena && (ena_cnt >= 3) && (ena_cnt <= 5);
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [1:0] s, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_sel = s; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        check("idle_wait", busy, 0);
        tick();
        tick();
    endtask

    task automatic go(input logic [1:0] f, input logic [2:0] n, input logic [7:0] p);
        start = 1'b1; first_prof = f; num_prof = n; num_pass = p;
        tick();
        start = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] ts, input logic [7:0] tg,
                                input logic [15:0] tgt, input logic [15:0] tl,
                                input logic [15:0] gc, input logic [1:0] prof,
                                input logic zero);
        exp_t e;
        e.ts = ts; e.tg = tg; e.tgt = tgt; e.tl = tl;
        e.gc = gc; e.prof = prof; e.zero = zero;
        return e;
    endfunction

    initial begin
        fork
            begin : monitor
                exp_t e;
                while (!tb_done) begin
                    @(negedge clk);
                    if (busy && tmr_rst) begin
                        n_load++;
                        prof_log.push_back(cur_prof);
                    end
                    if (busy && !tmr_rst && !tmr_ena) n_gap++;
                    if (tmr_ena) n_ena++;
                    if (seq_done) begin
                        if (sb.size() == 0) begin
                            check("unexpected_seq_done", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            check("sd_busy", busy, 0);
                            check("sd_trigger", e.zero ? prev_start : prev_done, 1);
                            check("sd_gate_cnt", gate_cnt, e.gc);
                            check("sd_cur_prof", cur_prof, e.prof);
                            check("sd_Tsync", tmr_Tsync, e.ts);
                            check("sd_Tgdel", tmr_Tgdel, e.tg);
                            check("sd_Tgate", tmr_Tgate, e.tgt);
                            check("sd_Tlen", tmr_Tlen, e.tl);
                        end
                    end
                    prev_start = start;
                    prev_done  = tmr_Done;
                end
            end
            begin : stimulus
                int l0, g0, e0, bad;
                repeat (3) @(posedge clk);
                #1;
                check("rst_busy", busy, 0);
                check("rst_seq_done", seq_done, 0);
                check("rst_ena", tmr_ena, 0);
                check("rst_tmr_rst", tmr_rst, 1);
                check("rst_wdog", wdog_err, 0);
                check("rst_cur_prof", cur_prof, 0);
                check("rst_gate_cnt", gate_cnt, 0);
                check("rst_T", {tmr_Tsync, tmr_Tgdel, tmr_Tgate}, 0);
                rst = 1'b1;
                tick();

                cfg_wr(0, 0, 2);      cfg_wr(0, 1, 3);      cfg_wr(0, 2, 4);      cfg_wr(0, 3, 5);
                cfg_wr(1, 0, 16'h11); cfg_wr(1, 1, 16'h12); cfg_wr(1, 2, 16'h13); cfg_wr(1, 3, 16'h11);
                cfg_wr(3, 0, 16'h31); cfg_wr(3, 1, 16'h32); cfg_wr(3, 2, 16'h33); cfg_wr(3, 3, 16'h34);

                // single run
                l0 = n_load; e0 = n_ena;
                sb.push_back(mk(2, 3, 4, 5, 1, 0, 0));
                go(0, 1, 1);
                wait_idle(200);
                check("single_loads", n_load - l0, 1);
                check("single_ena_cycles", n_ena - e0, 15);

                // wrap chain 3,0,3,0
                l0 = n_load; g0 = n_gap; e0 = n_ena;
                prof_log.delete();
                sb.push_back(mk(2, 3, 4, 5, 4, 0, 0));
                go(3, 2, 2);
                wait_idle(400);
                check("wrap_loads", n_load - l0, 4);
                check("wrap_gaps", n_gap - g0, 3);
                check("wrap_ena_cycles", n_ena - e0, 60);
                check("wrap_log_len", prof_log.size(), 4);
                if (prof_log.size() == 4)
                    check("wrap_prof_seq", {prof_log[0], prof_log[1], prof_log[2], prof_log[3]}, 8'b11_00_11_00);

                // zero work
                sb.push_back(mk(2, 3, 4, 5, 4, 0, 1));
                bad = 0;
                go(0, 0, 1);
                repeat (4) begin
                    if (busy || !tmr_rst) bad++;
                    tick();
                end
                check("zero_busy_or_rst", bad, 0);

                // abort together with Done in the 5th RUN cycle
                done_at = 5;
                go(0, 1, 1);
                bad = 0;
                while (!tmr_ena && bad < 10) begin tick(); bad++; end
                check("abort_reach_run", tmr_ena, 1);
                repeat (4) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_ena", tmr_ena, 0);
                check("abort_tmr_rst", tmr_rst, 1);
                check("abort_gate_cnt", gate_cnt, 1);
                repeat (5) tick();
                check("abort_gate_hold", gate_cnt, 1);
                done_at = 15;

                // write while busy is dropped
                sb.push_back(mk(2, 3, 4, 5, 1, 0, 0));
                go(0, 1, 1);
                repeat (3) tick();
                cfg_wr(1, 3, 9);
                wait_idle(200);
                sb.push_back(mk(8'h11, 8'h12, 16'h13, 16'h11, 1, 1, 0));
                go(1, 1, 1);
                wait_idle(200);

                // write together with start is used by LOAD
                sb.push_back(mk(8'h11, 8'h12, 16'h13, 7, 1, 1, 0));
                cfg_we = 1'b1; cfg_addr = 1; cfg_sel = 3; cfg_wdata = 7;
                go(1, 1, 1);
                cfg_we = 1'b0;
                tick();
                check("collide_Tlen", tmr_Tlen, 7);
                wait_idle(200);

`ifdef SEQ_WDOG_EN
                done_at = 0;
                e0 = n_ena;
                go(0, 1, 1);
                wait_idle(400);
                check("wdog_run_cycles", n_ena - e0, 100);
                check("wdog_err_set", wdog_err, 1);
                done_at = 15;
`endif

                // reset mid-sequence
                go(1, 1, 1);
                repeat (3) tick();
                check("mid_wdog_clear", wdog_err, 0);
                rst = 1'b0;
                #1;
                check("mid_rst_busy", busy, 0);
                check("mid_rst_ctl", {tmr_rst, tmr_ena}, 2'b10);
                check("mid_rst_Tlen", tmr_Tlen, 0);
                check("mid_rst_cur_prof", cur_prof, 0);
                tick();
                rst = 1'b1;
                tick();
                sb.push_back(mk(0, 0, 0, 0, 1, 1, 0));
                go(1, 1, 1);
                wait_idle(200);

                tick();
                tb_done = 1'b1;
                tick();
            end
        join
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
